// File: rtl/updown_pkg.sv
// Shared definitions for the up/down triangle stream: FSM states, direction
// encoding and the next-value prediction used by checker and counter models.
package updown_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCK
  } state_t;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  typedef struct packed {
    logic [31:0] val;
    logic        dir;
  } pred_t;

  // Successor of accepted value v reached in direction d on a 0..max triangle.
  function automatic pred_t next_val(input logic [31:0] v, input logic d,
                                     input logic [31:0] max);
    pred_t p;
    if (d == UP && v == max) begin
      p.val = max - 32'd1;
      p.dir = DN;
    end else if (d == DN && v == 32'd0) begin
      p.val = 32'd1;
      p.dir = UP;
    end else if (d == UP) begin
      p.val = v + 32'd1;
      p.dir = UP;
    end else begin
      p.val = v - 32'd1;
      p.dir = DN;
    end
    return p;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/updown_seq_checker.sv
// Phase-locking checker for the 0..MAX..0 triangle count stream: locks after
// LOCK_LEN legal successors, then predicts every sample and flags deviations.
module updown_seq_checker
  import updown_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             peak,
  output logic             trough
);

  localparam int               MW  = $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] MAX = '1;

  // Packs {dir, value} of the predicted next sample.
  function automatic logic [WIDTH:0] predict(input logic [WIDTH-1:0] v,
                                             input logic d);
    pred_t p;
    p = next_val(32'(v), d, 32'(MAX));
    return {p.dir, p.val[WIDTH-1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] exp_d;
  logic             dir_d, locked_d, err_d, peak_d, trough_d;
  logic             step_ok, step_dir;
  logic [WIDTH:0]   pred;

  // Legal successor of the reference sample while hunting for phase.
  always_comb begin
    step_ok  = 1'b0;
    step_dir = UP;
    if (ref_q == '0) begin
      step_ok = (count_in == WIDTH'(1));
    end else if (ref_q == MAX) begin
      step_ok  = (count_in == MAX - WIDTH'(1));
      step_dir = DN;
    end else if (count_in == ref_q + WIDTH'(1)) begin
      step_ok = 1'b1;
    end else if (count_in == ref_q - WIDTH'(1)) begin
      step_ok  = 1'b1;
      step_dir = DN;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold/idle default before any
    // branch, so no path leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    dir_d    = dir;
    exp_d    = expected;
    locked_d = locked;
    err_d    = 1'b0;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    pred     = '0;

    if (valid_in) begin
      ref_d = count_in;
      case (state_q)
        HUNT: begin
          match_d = '0;
          state_d = SYNC;
        end
        SYNC: begin
          if (step_ok) begin
            pred  = predict(count_in, step_dir);
            dir_d = pred[WIDTH];
            exp_d = pred[WIDTH-1:0];
            if (int'(match_q) + 1 >= LOCK_LEN) begin
              match_d  = '0;
              state_d  = LOCK;
              locked_d = 1'b1;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          if (count_in == expected) begin
            pred     = predict(count_in, dir);
            dir_d    = pred[WIDTH];
            exp_d    = pred[WIDTH-1:0];
            peak_d   = (count_in == MAX);
            trough_d = (count_in == '0);
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = SYNC;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      ref_q    <= '0;
      match_q  <= '0;
      locked   <= 1'b0;
      dir      <= UP;
      expected <= '0;
      err      <= 1'b0;
      peak     <= 1'b0;
      trough   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      locked   <= locked_d;
      dir      <= dir_d;
      expected <= exp_d;
      err      <= err_d;
      peak     <= peak_d;
      trough   <= trough_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .clr (rst),
    .inc (err_d),
    .q   (err_count)
  );

endmodule

// File: tb/tb_updown_seq_checker.sv
// Bench for updown_seq_checker: directed vector table, golden/saturation
// sequences, and random streams against a phase-based triangle model.
module tb_updown_seq_checker;

  localparam int MAX = 7;
  localparam int PER = 2 * MAX;

  logic       clk = 1'b0;
  logic       rst, valid_in;
  logic [2:0] count_in;

  logic       locked, dir, err, peak, trough;
  logic [2:0] expected;
  logic [7:0] err_count;

  logic       s_locked, s_dir, s_err, s_peak, s_trough;
  logic [2:0] s_expected;
  logic [1:0] s_err_count;

  always #5 clk = ~clk;

  updown_seq_checker #(.WIDTH(3), .LOCK_LEN(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
    .locked(locked), .dir(dir), .expected(expected), .err(err),
    .err_count(err_count), .peak(peak), .trough(trough)
  );

  updown_seq_checker #(.WIDTH(3), .LOCK_LEN(2), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
    .locked(s_locked), .dir(s_dir), .expected(s_expected), .err(s_err),
    .err_count(s_err_count), .peak(s_peak), .trough(s_trough)
  );

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: the triangle as a phase 0..PER-1 plus a run of legal
  // neighbour samples collected while out of lock.
  int m_hist[$];
  bit m_locked;
  int m_phase, m_exp, m_dir, m_ec;
  bit m_err, m_peak, m_trough;

  function automatic int tri_val(input int p);
    int q = p % PER;
    return (q <= MAX) ? q : PER - q;
  endfunction

  function automatic int dir_of(input int p);
    int q = p % PER;
    return (q >= 1 && q <= MAX) ? 0 : 1;
  endfunction

  task automatic model(input bit r, input bit v, input int s);
    m_err = 0; m_peak = 0; m_trough = 0;
    if (r) begin
      m_hist.delete();
      m_locked = 0; m_exp = 0; m_dir = 0; m_ec = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (m_hist.size() == 0) begin
          m_hist.push_back(s);
        end else if (s - m_hist[$] == 1 || m_hist[$] - s == 1) begin
          m_phase = (s > m_hist[$]) ? s : (PER - s) % PER;
          m_exp = tri_val(m_phase + 1);
          m_dir = dir_of(m_phase + 1);
          m_hist.push_back(s);
          if (m_hist.size() - 1 >= 2) begin
            m_locked = 1;
            m_hist.delete();
          end
        end else begin
          m_hist.delete();
          m_hist.push_back(s);
        end
      end else if (s == tri_val(m_phase + 1)) begin
        m_phase  = (m_phase + 1) % PER;
        m_exp    = tri_val(m_phase + 1);
        m_dir    = dir_of(m_phase + 1);
        m_peak   = (s == MAX);
        m_trough = (s == 0);
      end else begin
        m_err = 1;
        m_ec++;
        m_locked = 0;
        m_hist.delete();
        m_hist.push_back(s);
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int s);
    @(negedge clk);
    rst = r; valid_in = v; count_in = 3'(s);
    @(posedge clk);
    model(r, v, s);
    #1;
    if (s_err === 1'b1) err_pulses++;
    check("locked",     locked,      m_locked);
    check("dir",        dir,         m_dir);
    check("expected",   expected,    m_exp);
    check("err",        err,         m_err);
    check("peak",       peak,        m_peak);
    check("trough",     trough,      m_trough);
    check("err_count",  err_count,   (m_ec > 255) ? 255 : m_ec);
    check("sat_err",    s_err,       m_err);
    check("sat_count",  s_err_count, (m_ec > 3) ? 3 : m_ec);
  endtask

  typedef struct {
    bit r, v; int cnt;
    bit lk, dr; int ex; bit er, pk, tr; int ec;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int g;
    int ep0;
    bit r, v;
    int s;

    rst = 1'b1; valid_in = 1'b0; count_in = '0;

    // Mid-sequence start, valid gaps, glitch with relock, reset while locked.
    tbl.push_back('{1,0,0, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,5, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,4, 0,1,3,0,0,0,0});
    tbl.push_back('{0,1,3, 1,1,2,0,0,0,0});
    tbl.push_back('{0,1,2, 1,1,1,0,0,0,0});
    tbl.push_back('{0,1,1, 1,1,0,0,0,0,0});
    tbl.push_back('{0,1,0, 1,0,1,0,0,1,0});
    tbl.push_back('{0,0,6, 1,0,1,0,0,0,0});
    tbl.push_back('{0,0,3, 1,0,1,0,0,0,0});
    tbl.push_back('{0,0,0, 1,0,1,0,0,0,0});
    tbl.push_back('{0,1,1, 1,0,2,0,0,0,0});
    tbl.push_back('{0,1,2, 1,0,3,0,0,0,0});
    tbl.push_back('{0,1,3, 1,0,4,0,0,0,0});
    tbl.push_back('{0,1,2, 0,0,4,1,0,0,1});
    tbl.push_back('{0,1,1, 0,1,0,0,0,0,1});
    tbl.push_back('{0,1,0, 1,0,1,0,0,0,1});
    tbl.push_back('{0,1,1, 1,0,2,0,0,0,1});
    tbl.push_back('{0,1,2, 1,0,3,0,0,0,1});
    tbl.push_back('{0,1,3, 1,0,4,0,0,0,1});
    tbl.push_back('{0,1,4, 1,0,5,0,0,0,1});
    tbl.push_back('{0,1,5, 1,0,6,0,0,0,1});
    tbl.push_back('{0,1,6, 1,0,7,0,0,0,1});
    tbl.push_back('{0,1,7, 1,1,6,0,1,0,1});
    tbl.push_back('{0,1,5, 0,1,6,1,0,0,2});
    tbl.push_back('{0,1,4, 0,1,3,0,0,0,2});
    tbl.push_back('{0,1,3, 1,1,2,0,0,0,2});
    tbl.push_back('{1,1,4, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,4, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,5, 0,0,6,0,0,0,0});
    tbl.push_back('{0,1,6, 1,0,7,0,0,0,0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].cnt);
      check($sformatf("vec%0d.locked", i),    locked,    tbl[i].lk);
      check($sformatf("vec%0d.dir", i),       dir,       tbl[i].dr);
      check($sformatf("vec%0d.expected", i),  expected,  tbl[i].ex);
      check($sformatf("vec%0d.err", i),       err,       tbl[i].er);
      check($sformatf("vec%0d.peak", i),      peak,      tbl[i].pk);
      check($sformatf("vec%0d.trough", i),    trough,    tbl[i].tr);
      check($sformatf("vec%0d.err_count", i), err_count, tbl[i].ec);
    end

    // Golden stream: three full periods ending on 0.
    step(1, 0, 0);
    for (int i = 0; i <= 3 * PER; i++) begin
      step(0, 1, tri_val(i));
      check("gold.locked", locked, (i >= 2));
      check("gold.peak",   peak,   (i % PER == MAX));
      check("gold.trough", trough, (i > 0 && i % PER == 0));
      check("gold.err",    err,    0);
      check("gold.err_cnt", err_count, 0);
    end

    // Saturation: five isolated errors, relocking in between.
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    ep0 = err_pulses;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 6); step(0, 1, 5); step(0, 1, 4);
      check("sat.relocked", s_locked, 1);
    end
    check("sat.pulses",     err_pulses - ep0, 5);
    check("sat.count_w8",   err_count,        5);
    check("sat.count_w2",   s_err_count,      3);

    // Random mostly-legal stream with glitches, gaps and rare resets.
    step(1, 0, 0);
    g = $urandom_range(0, PER - 1);
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 85);
      if (v && $urandom_range(0, 9) != 0) begin
        s = tri_val(g);
        g++;
      end else begin
        s = $urandom_range(0, MAX);
      end
      step(r, v, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
